// File: rtl/imem_port_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_port_if
// Purpose  : Bundles the fetch-stage and instruction-memory signals of
//            imem_port. The master view belongs to imem_port itself; the
//            slave view belongs to the fetch stage / memory side.
// Revision : 1.0  initial release
// ============================================================================
interface imem_port_if;
  logic [31:0] Addr_fIF;
  logic [31:0] Instr_2IF;
  logic        Stall_2IF;
  logic        Mem_Req;
  logic [31:0] Mem_Addr;
  logic        Mem_Ack;
  logic [31:0] Mem_RData;
  logic        Bus_Err;
  logic [15:0] Miss_Count;

  modport master (
    input  Addr_fIF, Mem_Ack, Mem_RData,
    output Instr_2IF, Stall_2IF, Mem_Req, Mem_Addr, Bus_Err, Miss_Count
  );

  modport slave (
    output Addr_fIF, Mem_Ack, Mem_RData,
    input  Instr_2IF, Stall_2IF, Mem_Req, Mem_Addr, Bus_Err, Miss_Count
  );
endinterface
`default_nettype wire

// File: rtl/imem_port.sv
`default_nettype none
// ============================================================================
// Module   : imem_port
// Purpose  : Instruction fetch port with a small fill buffer. Hits are served
//            combinationally; a miss stalls fetch, reads memory with a
//            per-beat timeout, and refills the buffer.
//            Macro IMEM_LINEBUF_EN: when defined, the buffer is a 4-word line
//            filled in 4 beats; when undefined, a single word, one beat.
// Revision : 1.0  initial release
// ============================================================================
module imem_port #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  wire logic   CLK,
  input  wire logic   RESET,
  imem_port_if.master bus
);

`ifdef IMEM_LINEBUF_EN
  localparam int C_NWORDS  = 4;
  localparam int C_TAG_LSB = 4;
`else
  localparam int C_NWORDS  = 1;
  localparam int C_TAG_LSB = 2;
`endif
  localparam int C_TAG_W   = 32 - C_TAG_LSB;
  localparam logic [31:0] C_BASE_MASK = ~((32'd1 << C_TAG_LSB) - 32'd1);
  localparam int C_WAIT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_WAIT_W-1:0] C_WAIT_LAST = C_WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [C_TAG_W-1:0]    r_tag;
  logic [C_NWORDS-1:0]   r_valid;
  logic [31:0]           r_data [C_NWORDS];
  logic [31:0]           r_mem_addr;
  logic [C_WAIT_W-1:0]   r_wait;
  logic [15:0]           r_miss_count;
  logic                  r_bus_err;

  logic                  w_word_valid;
  logic [31:0]           w_word_data;
  logic                  w_last_beat;
  logic                  w_hit;
  logic                  w_mem_req;
  logic                  w_start;
  logic                  w_beat_ack;
  logic                  w_timeout;

`ifdef IMEM_LINEBUF_EN
  logic [1:0]            r_beat;
  logic [1:0]            w_idx;

  assign w_idx        = bus.Addr_fIF[3:2];
  assign w_word_valid = r_valid[w_idx];
  assign w_word_data  = r_data[w_idx];
  assign w_last_beat  = (r_beat == 2'd3);
`else
  assign w_word_valid = r_valid[0];
  assign w_word_data  = r_data[0];
  assign w_last_beat  = 1'b1;
`endif

  // Hit needs the addressed word valid and the buffer tag to match the fetch
  assign w_hit = w_word_valid && (r_tag == bus.Addr_fIF[31:C_TAG_LSB]);

  assign bus.Instr_2IF  = w_hit ? w_word_data : 32'h0000_0000;
  assign bus.Stall_2IF  = !w_hit;
  assign bus.Mem_Req    = w_mem_req;
  assign bus.Mem_Addr   = r_mem_addr;
  assign bus.Bus_Err    = r_bus_err;
  assign bus.Miss_Count = r_miss_count;

  // State register; reset drops straight to IDLE so Mem_Req falls at once
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle controls: start on a miss, finish on last beat or timeout
  always_comb begin
    w_state_nxt = r_state;
    w_mem_req   = 1'b0;
    w_start     = 1'b0;
    w_beat_ack  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_hit) begin
          w_start     = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_mem_req = 1'b1;
        if (bus.Mem_Ack) begin
          w_beat_ack = 1'b1;
          if (w_last_beat) begin
            w_state_nxt = S_IDLE;
          end
        end else if (r_wait == C_WAIT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Buffer: retag and invalidate on a new miss, fill per accepted beat, drop all on timeout
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_tag   <= '0;
      r_valid <= '0;
      for (int i = 0; i < C_NWORDS; i++) begin
        r_data[i] <= '0;
      end
    end else if (w_start) begin
      r_tag   <= bus.Addr_fIF[31:C_TAG_LSB];
      r_valid <= '0;
    end else if (w_beat_ack) begin
`ifdef IMEM_LINEBUF_EN
      r_data[r_beat]  <= bus.Mem_RData;
      r_valid[r_beat] <= 1'b1;
`else
      r_data[0]  <= bus.Mem_RData;
      r_valid[0] <= 1'b1;
`endif
    end else if (w_timeout) begin
      r_valid <= '0;
    end
  end

  // Read address, beat position and per-beat wait counter
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_mem_addr <= '0;
      r_wait     <= '0;
`ifdef IMEM_LINEBUF_EN
      r_beat     <= '0;
`endif
    end else if (w_start) begin
      // Masking keeps the request aligned to the buffer granule
      r_mem_addr <= bus.Addr_fIF & C_BASE_MASK;
      r_wait     <= '0;
`ifdef IMEM_LINEBUF_EN
      r_beat     <= '0;
`endif
    end else if (w_beat_ack) begin
      r_wait <= '0;
`ifdef IMEM_LINEBUF_EN
      if (!w_last_beat) begin
        r_mem_addr <= r_mem_addr + 32'd4;
        r_beat     <= r_beat + 2'd1;
      end
`endif
    end else if (w_timeout) begin
      r_wait <= '0;
    end else if (r_state == S_BUSY) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  // Miss counter (wraps) and one-cycle bus error pulse after a timeout
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_miss_count <= '0;
      r_bus_err    <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
      if (w_start) begin
        r_miss_count <= r_miss_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire
